// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline types: EX/MEM and MEM/WB records, MEM-stage FSM states,
// and byte-lane helpers for the data-memory port.
package riscv_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    MEM_BYTE   = 3'd0,
    MEM_HALF   = 3'd1,
    MEM_WORD   = 3'd2,
    MEM_BYTE_U = 3'd4,
    MEM_HALF_U = 3'd5
  } mem_op_e;

  typedef struct packed {
    logic    mem_read;
    logic    mem_write;
    mem_op_e mem_op;
    logic    reg_write;
    logic    mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] rs2_data;
    logic [4:0]        rd_addr;
    mem_ctrl_t         ctrl;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] load_data;
    logic [4:0]        rd_addr;
    logic              reg_write;
    logic              mem_to_reg;
  } mem_wb_reg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } mem_stage_e;

  // Clamp the byte offset to the natural alignment of the access size.
  function automatic logic [1:0] align_offset(mem_op_e op, logic [1:0] o);
    case (op)
      MEM_HALF, MEM_HALF_U: align_offset = {o[1], 1'b0};
      MEM_WORD:             align_offset = 2'b00;
      default:              align_offset = o;
    endcase
  endfunction

  function automatic logic is_misaligned(mem_op_e op, logic [1:0] o);
    case (op)
      MEM_HALF, MEM_HALF_U: is_misaligned = o[0];
      MEM_WORD:             is_misaligned = (o != 2'b00);
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_be(mem_op_e op, logic [1:0] o);
    case (op)
      MEM_BYTE, MEM_BYTE_U: store_be = 4'b0001 << o;
      MEM_HALF, MEM_HALF_U: store_be = 4'b0011 << {o[1], 1'b0};
      default:              store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_wdata(mem_op_e op, logic [DATA_W-1:0] rs2);
    case (op)
      MEM_BYTE, MEM_BYTE_U: store_wdata = {4{rs2[7:0]}};
      MEM_HALF, MEM_HALF_U: store_wdata = {2{rs2[15:0]}};
      default:              store_wdata = rs2;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(mem_op_e op, logic [1:0] o,
                                                    logic [DATA_W-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{o, 3'b000} +: 8];
    h = rdata[{o[1], 4'b0000} +: 16];
    case (op)
      MEM_BYTE:   load_extend = {{24{b[7]}}, b};
      MEM_BYTE_U: load_extend = {24'd0, b};
      MEM_HALF:   load_extend = {{16{h[15]}}, h};
      MEM_HALF_U: load_extend = {16'd0, h};
      default:    load_extend = rdata;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half from a returned memory word and
// sign- or zero-extends it according to the load type.
module load_align
  import riscv_pkg::*;
(
  input  logic [2:0]        mem_op_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o
);

  assign data_o = load_extend(mem_op_e'(mem_op_i), offset_i, rdata_i);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the req/gnt/rvalid data bus and
// stalls the pipe until each access completes. Optional DMEM_MISALIGN_EXC_EN
// traps misaligned half/word accesses instead of forcing natural alignment.
module mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RESP_TO = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_reg_t       in,
  output mem_wb_reg_t       out,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_err,
`ifdef DMEM_MISALIGN_EXC_EN
  output logic              misalign_exc,
`endif
  output logic [1:0]        dbg_state
);

  localparam int unsigned CNT_W = (RESP_TO > 2) ? $clog2(RESP_TO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((RESP_TO > 0) ? RESP_TO - 1 : 0);

  mem_stage_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              acc, is_load, misaligned, timeout_hit;
  logic [1:0]        off;
  logic [DATA_W-1:0] aligned_data;
  logic              req_c, stall_c, err_c, misal_c, load_done_c;
  mem_wb_reg_t       out_c;

  assign acc     = in.ctrl.mem_read | in.ctrl.mem_write;
  assign is_load = in.ctrl.mem_read;
  assign off     = align_offset(in.ctrl.mem_op, in.alu_result[1:0]);

`ifdef DMEM_MISALIGN_EXC_EN
  assign misaligned = acc & is_misaligned(in.ctrl.mem_op, in.alu_result[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // Counter value k means k+1 cycles spent in WAIT_R, so the error lands
  // exactly RESP_TO cycles after the grant.
  assign timeout_hit = (RESP_TO != 0) && (cnt_q == CNT_MAX);

  load_align u_load_align (
    .mem_op_i (in.ctrl.mem_op),
    .offset_i (off),
    .rdata_i  (dmem_rdata),
    .data_o   (aligned_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    err_c       = 1'b0;
    misal_c     = 1'b0;
    load_done_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (acc && misaligned) begin
          misal_c = 1'b1;
        end else if (acc) begin
          req_c = 1'b1;
          if (is_load) begin
            stall_c = 1'b1;
            state_d = dmem_gnt ? WAIT_R : REQ;
          end else if (!dmem_gnt) begin
            stall_c = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dmem_gnt) begin
          if (is_load) begin
            state_d = WAIT_R;
          end else begin
            stall_c = 1'b0;
            state_d = IDLE;
          end
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) begin
          load_done_c = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end else if (timeout_hit) begin
          err_c   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_c            = '0;
    out_c.alu_result = in.alu_result;
    out_c.rd_addr    = in.rd_addr;
    out_c.reg_write  = in.ctrl.reg_write & ~misal_c;
    out_c.mem_to_reg = in.ctrl.mem_to_reg;
    out_c.load_data  = load_done_c ? aligned_data : '0;
  end

  // Everything is gated by reset so the bus and pipe see zeros while it is held.
  assign out        = reset ? out_c : '0;
  assign mem_stall  = reset & stall_c;
  assign dmem_req   = reset & req_c;
  assign dmem_we    = reset & req_c & in.ctrl.mem_write & ~in.ctrl.mem_read;
  assign dmem_addr  = reset ? {in.alu_result[31:2], 2'b00} : '0;
  assign dmem_be    = reset ? store_be(in.ctrl.mem_op, off) : 4'b0000;
  assign dmem_wdata = reset ? store_wdata(in.ctrl.mem_op, in.rs2_data) : '0;
  assign dmem_err   = reset & err_c;
  assign dbg_state  = reset ? state_q : IDLE;

`ifdef DMEM_MISALIGN_EXC_EN
  assign misalign_exc = reset & misal_c;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: store/non-memory vector table, load extension
// table, and hand sequences for delayed grant, timeout, reset and misalignment.
module tb_mem_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  ex_mem_reg_t ex_in;
  mem_wb_reg_t wb_out;
  logic        mem_stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [1:0]  dbg_state;
`ifdef DMEM_MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage #(.XLEN(32), .RESP_TO(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (ex_in),
    .out         (wb_out),
    .mem_stall   (mem_stall),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .dmem_err    (dmem_err),
`ifdef DMEM_MISALIGN_EXC_EN
    .misalign_exc(misalign_exc),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  // driver tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input mem_op_e op,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rda);
    ex_in                 = '0;
    ex_in.alu_result      = addr;
    ex_in.rs2_data        = rs2;
    ex_in.rd_addr         = rda;
    ex_in.ctrl.mem_read   = rd;
    ex_in.ctrl.mem_write  = wr;
    ex_in.ctrl.mem_op     = op;
    ex_in.ctrl.reg_write  = ~wr | rd;
    ex_in.ctrl.mem_to_reg = rd;
  endtask

  task automatic nop(input logic [31:0] res);
    drive(1'b0, 1'b0, MEM_WORD, res, 32'h0, 5'd1);
  endtask

  typedef struct {
    logic        wr;
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } st_vec_t;

  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } ld_vec_t;

  st_vec_t sv[8];
  ld_vec_t lv[8];

  initial begin
    sv[0] = '{1'b1, MEM_WORD, 32'h100, 32'hDEADBEEF, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF};
    sv[1] = '{1'b1, MEM_BYTE, 32'h103, 32'h000000A5, 1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5};
    sv[2] = '{1'b1, MEM_BYTE, 32'h101, 32'h12345678, 1'b1, 32'h100, 4'b0010, 32'h78787878};
    sv[3] = '{1'b1, MEM_HALF, 32'h102, 32'hCAFE1234, 1'b1, 32'h100, 4'b1100, 32'h12341234};
    sv[4] = '{1'b1, MEM_HALF, 32'h200, 32'h0000BEEF, 1'b1, 32'h200, 4'b0011, 32'hBEEFBEEF};
    sv[5] = '{1'b1, MEM_WORD, 32'h10C, 32'h01020304, 1'b1, 32'h10C, 4'b1111, 32'h01020304};
    sv[6] = '{1'b0, MEM_WORD, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0};
    sv[7] = '{1'b0, MEM_BYTE, 32'h00000007, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0};

    lv[0] = '{MEM_BYTE,   32'h101, 32'h00008000, 32'hFFFFFF80};
    lv[1] = '{MEM_BYTE_U, 32'h101, 32'h00008000, 32'h00000080};
    lv[2] = '{MEM_HALF,   32'h102, 32'h80010000, 32'hFFFF8001};
    lv[3] = '{MEM_HALF_U, 32'h102, 32'h80010000, 32'h00008001};
    lv[4] = '{MEM_WORD,   32'h104, 32'hA5A55A5A, 32'hA5A55A5A};
    lv[5] = '{MEM_BYTE,   32'h100, 32'h0000007F, 32'h0000007F};
    lv[6] = '{MEM_BYTE_U, 32'h103, 32'hFE000000, 32'h000000FE};
    lv[7] = '{MEM_HALF,   32'h100, 32'h1234F00F, 32'hFFFFF00F};

    // reset state, with a store presented so gating is visible
    reset = 1'b0; dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = '0;
    drive(1'b0, 1'b1, MEM_WORD, 32'h100, 32'hDEADBEEF, 5'd0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(mem_stall), 32'd0);
    check("rst_alu", wb_out.alu_result, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b1; dmem_gnt = 1'b0; nop(32'h0);

    // store / non-memory table: grant in the request cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b0, sv[i].wr, sv[i].op, sv[i].addr, sv[i].rs2, 5'd3);
      dmem_gnt = 1'b1;
      #1;
      check($sformatf("st%0d_req", i), 32'(dmem_req), 32'(sv[i].exp_req));
      check($sformatf("st%0d_stall", i), 32'(mem_stall), 32'd0);
      check($sformatf("st%0d_alu", i), wb_out.alu_result, sv[i].addr);
      check($sformatf("st%0d_ld", i), wb_out.load_data, 32'd0);
      if (sv[i].exp_req) begin
        check($sformatf("st%0d_we", i), 32'(dmem_we), 32'd1);
        check($sformatf("st%0d_addr", i), dmem_addr, sv[i].exp_addr);
        check($sformatf("st%0d_be", i), 32'(dmem_be), 32'(sv[i].exp_be));
        check($sformatf("st%0d_wd", i), dmem_wdata, sv[i].exp_wdata);
      end
    end
    @(negedge clk);
    dmem_gnt = 1'b0; nop(32'h0);
    #1;
    check("st_state_idle", 32'(dbg_state), 32'(IDLE));

    // load table: grant, one wait cycle, then rvalid
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, lv[i].op, lv[i].addr, 32'h0, 5'd9);
      dmem_gnt = 1'b1; dmem_rvalid = 1'b0; dmem_rdata = '0;
      #1;
      check($sformatf("ld%0d_req", i), 32'(dmem_req), 32'd1);
      check($sformatf("ld%0d_we", i), 32'(dmem_we), 32'd0);
      check($sformatf("ld%0d_stall_g", i), 32'(mem_stall), 32'd1);
      check($sformatf("ld%0d_addr", i), dmem_addr, {lv[i].addr[31:2], 2'b00});
      @(negedge clk);
      dmem_gnt = 1'b0;
      #1;
      check($sformatf("ld%0d_stall_w", i), 32'(mem_stall), 32'd1);
      check($sformatf("ld%0d_req_w", i), 32'(dmem_req), 32'd0);
      @(negedge clk);
      dmem_rvalid = 1'b1; dmem_rdata = lv[i].rdata;
      #1;
      check($sformatf("ld%0d_stall_v", i), 32'(mem_stall), 32'd0);
      check($sformatf("ld%0d_data", i), wb_out.load_data, lv[i].exp);
      check($sformatf("ld%0d_rd", i), 32'(wb_out.rd_addr), 32'd9);
    end
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = '0; nop(32'h0);

    // SB with grant held off for three cycles: request must stay stable
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, MEM_BYTE, 32'h103, 32'h000000A5, 5'd0);
      dmem_gnt = (c == 3);
      #1;
      check($sformatf("dg%0d_req", c), 32'(dmem_req), 32'd1);
      check($sformatf("dg%0d_stall", c), 32'(mem_stall), (c == 3) ? 32'd0 : 32'd1);
      check($sformatf("dg%0d_be", c), 32'(dmem_be), 32'(4'b1000));
      check($sformatf("dg%0d_wd", c), dmem_wdata, 32'hA5A5A5A5);
      check($sformatf("dg%0d_addr", c), dmem_addr, 32'h100);
    end
    @(negedge clk);
    dmem_gnt = 1'b0; nop(32'h0);
    #1;
    check("dg_state_idle", 32'(dbg_state), 32'(IDLE));

    // LW through REQ with stale rvalid in IDLE and REQ (ignored)
    @(negedge clk);
    drive(1'b1, 1'b0, MEM_WORD, 32'h108, 32'h0, 5'd4);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBADBAD00;
    #1;
    check("stale_idle_stall", 32'(mem_stall), 32'd1);
    check("stale_idle_ld", wb_out.load_data, 32'd0);
    @(negedge clk);
    dmem_gnt = 1'b1;
    #1;
    check("stale_req_stall", 32'(mem_stall), 32'd1);
    check("stale_req_ld", wb_out.load_data, 32'd0);
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    check("stale_wait_stall", 32'(mem_stall), 32'd1);
    check("stale_wait_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
    #1;
    check("stale_done_stall", 32'(mem_stall), 32'd0);
    check("stale_done_ld", wb_out.load_data, 32'h11223344);
    @(negedge clk);
    dmem_rvalid = 1'b0; nop(32'h0);

    // timeout: grant, no rvalid, error four cycles later
    @(negedge clk);
    drive(1'b1, 1'b0, MEM_WORD, 32'h110, 32'h0, 5'd6);
    dmem_gnt = 1'b1;
    #1;
    check("to_req", 32'(dmem_req), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      #1;
      check($sformatf("to%0d_err", c), 32'(dmem_err), (c == 4) ? 32'd1 : 32'd0);
      check($sformatf("to%0d_stall", c), 32'(mem_stall), (c == 4) ? 32'd0 : 32'd1);
      check($sformatf("to%0d_ld", c), wb_out.load_data, 32'd0);
    end
    @(negedge clk);
    nop(32'h0);
    #1;
    check("to_after_err", 32'(dmem_err), 32'd0);
    check("to_state_idle", 32'(dbg_state), 32'(IDLE));

    // asynchronous reset while waiting for rvalid; late rvalid ignored
    @(negedge clk);
    drive(1'b1, 1'b0, MEM_WORD, 32'h120, 32'h0, 5'd7);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    check("ar_wait_state", 32'(dbg_state), 32'(WAIT_R));
    check("ar_wait_stall", 32'(mem_stall), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_req", 32'(dmem_req), 32'd0);
    check("ar_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; nop(32'h55); dmem_rvalid = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    check("ar_late_ld", wb_out.load_data, 32'd0);
    check("ar_late_stall", 32'(mem_stall), 32'd0);
    check("ar_late_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_rdata = '0;

    // SW at a misaligned address
    @(negedge clk);
    drive(1'b0, 1'b1, MEM_WORD, 32'h102, 32'h0BADF00D, 5'd0);
    ex_in.ctrl.reg_write = 1'b1;
    dmem_gnt = 1'b1;
    #1;
    check("mis_stall", 32'(mem_stall), 32'd0);
`ifdef DMEM_MISALIGN_EXC_EN
    check("mis_exc", 32'(misalign_exc), 32'd1);
    check("mis_req", 32'(dmem_req), 32'd0);
    check("mis_rw", 32'(wb_out.reg_write), 32'd0);
`else
    check("mis_req", 32'(dmem_req), 32'd1);
    check("mis_be", 32'(dmem_be), 32'(4'b1111));
    check("mis_addr", dmem_addr, 32'h100);
`endif
    @(negedge clk);
    dmem_gnt = 1'b0; nop(32'h0);
    #1;
    check("final_state", 32'(dbg_state), 32'(IDLE));

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
